// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU with one-bit-per-cycle shifter and accumulator.
//
// State table:
//   IDLE | no result held; waiting for an operation
//   EXEC | multi-cycle shift/rotate in progress, one bit per enabled cycle
//   DONE | result and flags held valid until the consumer takes them
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   CE                  clock enable; low freezes all state
//   in_valid/in_ready   operation handshake
//   OP_CODE             operation select
//   left_operand        operand A (or accumulator when acc_sel=1)
//   right_operand       operand B; low SHW bits are the shift/rotate amount
//   carry_in            carry/borrow in for ADD/SUB
//   acc_sel             use accumulator as operand A
//   out_valid/out_ready result handshake
//   op_out, carry_out, zero_flag, neg_flag, ovf_flag  registered result/flags
//   busy                multi-cycle operation in progress
module alu_seq #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            CE,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      OP_CODE,
  input  logic [SIZE-1:0] left_operand,
  input  logic [SIZE-1:0] right_operand,
  input  logic            carry_in,
  input  logic            acc_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] op_out,
  output logic            carry_out,
  output logic            zero_flag,
  output logic            neg_flag,
  output logic            ovf_flag,
  output logic            busy
);

  localparam int SHW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] work;
  logic [SHW-1:0]  cnt;
  logic [3:0]      op_reg;

  logic [SIZE-1:0] a_val;
  logic [SHW-1:0]  amt;
  logic            accept;
  logic            multi;
  logic            exec_last;

  logic [SIZE-1:0] res;
  logic [SIZE:0]   sum;
  logic            res_c;
  logic            res_v;

  logic [SIZE-1:0] sh_nxt;
  logic            sh_out;

  assign a_val     = acc_sel ? acc : left_operand;
  assign amt       = right_operand[SHW-1:0];
  assign in_ready  = CE && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  // Only shifts/rotates with a non-zero amount need the EXEC state.
  assign multi     = (OP_CODE >= 4'd10) && (OP_CODE <= 4'd13) && (amt != '0);
  assign exec_last = (state == EXEC) && (cnt == SHW'(1));

  assign out_valid = (state == DONE);
  assign busy      = (state == EXEC);

  // Single-cycle result path; shifts with amount 0 and reserved codes pass A.
  always_comb begin
    res   = a_val;
    sum   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (OP_CODE)
      4'd0: begin
        sum   = {1'b0, a_val} + {1'b0, right_operand} + {{SIZE{1'b0}}, carry_in};
        res   = sum[SIZE-1:0];
        res_c = sum[SIZE];
        res_v = (a_val[SIZE-1] == right_operand[SIZE-1]) && (res[SIZE-1] != a_val[SIZE-1]);
      end
      4'd1: begin
        // Bit SIZE of the extended difference is the borrow.
        sum   = {1'b0, a_val} - {1'b0, right_operand} - {{SIZE{1'b0}}, carry_in};
        res   = sum[SIZE-1:0];
        res_c = sum[SIZE];
        res_v = (a_val[SIZE-1] != right_operand[SIZE-1]) && (res[SIZE-1] != a_val[SIZE-1]);
      end
      4'd2: res = a_val & right_operand;
      4'd3: res = a_val | right_operand;
      4'd4: res = a_val ^ right_operand;
      4'd5: res = ~a_val;
      4'd6: res = a_val;
      4'd7: res = right_operand;
      4'd8: begin
        sum   = {1'b0, a_val} + (SIZE+1)'(1);
        res   = sum[SIZE-1:0];
        res_c = sum[SIZE];
        res_v = !a_val[SIZE-1] && res[SIZE-1];
      end
      4'd9: begin
        sum   = {1'b0, a_val} - (SIZE+1)'(1);
        res   = sum[SIZE-1:0];
        res_c = sum[SIZE];
        res_v = a_val[SIZE-1] && !res[SIZE-1];
      end
      default: res = a_val;
    endcase
  end

  // One-bit shift step; rotates never produce a carry.
  always_comb begin
    sh_nxt = work;
    sh_out = 1'b0;
    case (op_reg)
      4'd10: begin
        sh_nxt = {work[SIZE-2:0], 1'b0};
        sh_out = work[SIZE-1];
      end
      4'd11: begin
        sh_nxt = {1'b0, work[SIZE-1:1]};
        sh_out = work[0];
      end
      4'd12: sh_nxt = {work[SIZE-2:0], work[SIZE-1]};
      4'd13: sh_nxt = {work[0], work[SIZE-1:1]};
      default: sh_nxt = work;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else if (CE) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = multi ? EXEC : DONE;
      end
      EXEC: begin
        if (exec_last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = multi ? EXEC : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      work      <= '0;
      cnt       <= '0;
      op_reg    <= '0;
      op_out    <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (CE) begin
      if (accept) begin
        op_reg <= OP_CODE;
        work   <= a_val;
        cnt    <= amt;
        if (!multi) begin
          op_out    <= res;
          carry_out <= res_c;
          zero_flag <= (res == '0);
          neg_flag  <= res[SIZE-1];
          ovf_flag  <= res_v;
          acc       <= res;
        end
      end else if (state == EXEC) begin
        work <= sh_nxt;
        cnt  <= cnt - SHW'(1);
        if (exec_last) begin
          op_out    <= sh_nxt;
          carry_out <= sh_out;
          zero_flag <= (sh_nxt == '0);
          neg_flag  <= sh_nxt[SIZE-1];
          ovf_flag  <= 1'b0;
          acc       <= sh_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed vectors, expected results queued at
// acceptance and checked by a monitor when the DUT hands a result over.
module tb_alu_seq;

  logic       clk;
  logic       rstn;
  logic       CE;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] OP_CODE;
  logic [7:0] left_operand;
  logic [7:0] right_operand;
  logic       carry_in;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] op_out;
  logic       carry_out;
  logic       zero_flag;
  logic       neg_flag;
  logic       ovf_flag;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [11:0] sb[$];

  alu_seq #(.SIZE(8)) dut (
    .clk(clk), .rstn(rstn), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready),
    .OP_CODE(OP_CODE), .left_operand(left_operand), .right_operand(right_operand),
    .carry_in(carry_in), .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .carry_out(carry_out), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic [7:0] r, input logic c, z, n, v);
    return {r, c, z, n, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Result monitor: a transfer happens at the next edge when valid, ready and CE.
  always @(negedge clk) begin
    if (rstn && CE && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {20'd0, op_out, carry_out, zero_flag, neg_flag, ovf_flag}, 32'hFFFFFFFF);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("result{op,c,z,n,v}", {20'd0, op_out, carry_out, zero_flag, neg_flag, ovf_flag}, {20'd0, e});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, b, input logic cin, sel,
                       input logic [11:0] e, input bit push);
    int w;
    w = 0;
    OP_CODE = op; left_operand = a; right_operand = b; carry_in = cin; acc_sel = sel;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [7:0] a, b,
                     input logic cin, sel, input logic [11:0] e, input int exp_lat, exp_busy);
    int lat;
    int bc;
    issue(op, a, b, cin, sel, e, 1'b1);
    lat = 1;
    bc  = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, bc, exp_busy);
    step();
  endtask

  initial begin
    int n;
    rstn = 1'b0; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    OP_CODE = 4'd0; left_operand = 8'd0; right_operand = 8'd0; carry_in = 1'b0; acc_sel = 1'b0;
    #12 rstn = 1'b1;
    step();
    chk("reset_op_out", op_out, 8'h00);
    chk("reset_flags", {carry_out, zero_flag, neg_flag, ovf_flag}, 4'b0000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    run("add_1_1",   4'd0,  8'h01, 8'h01, 1'b0, 1'b0, ex(8'h02, 0, 0, 0, 0), 1, 0);
    run("sub_1_2",   4'd1,  8'h01, 8'h02, 1'b0, 1'b0, ex(8'hFF, 1, 0, 1, 0), 1, 0);
    run("add_ovf",   4'd0,  8'h7F, 8'h01, 1'b0, 1'b0, ex(8'h80, 0, 0, 1, 1), 1, 0);
    run("add_cin",   4'd0,  8'hFF, 8'h00, 1'b1, 1'b0, ex(8'h00, 1, 1, 0, 0), 1, 0);
    run("sub_ovf",   4'd1,  8'h80, 8'h01, 1'b0, 1'b0, ex(8'h7F, 0, 0, 0, 1), 1, 0);
    run("sub_cin",   4'd1,  8'h05, 8'h03, 1'b1, 1'b0, ex(8'h01, 0, 0, 0, 0), 1, 0);
    run("and",       4'd2,  8'hF0, 8'h3C, 1'b0, 1'b0, ex(8'h30, 0, 0, 0, 0), 1, 0);
    run("or",        4'd3,  8'hF0, 8'h0F, 1'b0, 1'b0, ex(8'hFF, 0, 0, 1, 0), 1, 0);
    run("xor",       4'd4,  8'h0F, 8'h0F, 1'b0, 1'b0, ex(8'h00, 0, 1, 0, 0), 1, 0);
    run("not",       4'd5,  8'h0F, 8'h00, 1'b0, 1'b0, ex(8'hF0, 0, 0, 1, 0), 1, 0);
    run("ld",        4'd6,  8'h5A, 8'h00, 1'b0, 1'b0, ex(8'h5A, 0, 0, 0, 0), 1, 0);
    run("st",        4'd7,  8'h00, 8'hA5, 1'b0, 1'b0, ex(8'hA5, 0, 0, 1, 0), 1, 0);
    run("inc_wrap",  4'd8,  8'hFF, 8'h00, 1'b0, 1'b0, ex(8'h00, 1, 1, 0, 0), 1, 0);
    run("inc_ovf",   4'd8,  8'h7F, 8'h00, 1'b0, 1'b0, ex(8'h80, 0, 0, 1, 1), 1, 0);
    run("dec_wrap",  4'd9,  8'h00, 8'h00, 1'b0, 1'b0, ex(8'hFF, 1, 0, 1, 0), 1, 0);
    run("dec_ovf",   4'd9,  8'h80, 8'h00, 1'b0, 1'b0, ex(8'h7F, 0, 0, 0, 1), 1, 0);
    run("rsv14",     4'd14, 8'h33, 8'hFF, 1'b1, 1'b0, ex(8'h33, 0, 0, 0, 0), 1, 0);
    run("rsv15",     4'd15, 8'h80, 8'h01, 1'b0, 1'b0, ex(8'h80, 0, 0, 1, 0), 1, 0);
    run("shl_3",     4'd10, 8'h10, 8'h03, 1'b0, 1'b0, ex(8'h80, 0, 0, 1, 0), 4, 3);
    run("shr_5",     4'd11, 8'h10, 8'h05, 1'b0, 1'b0, ex(8'h00, 1, 1, 0, 0), 6, 5);
    run("ror_1",     4'd13, 8'h01, 8'h01, 1'b0, 1'b0, ex(8'h80, 0, 0, 1, 0), 2, 1);
    run("rol_1",     4'd12, 8'h81, 8'h01, 1'b0, 1'b0, ex(8'h03, 0, 0, 0, 0), 2, 1);
    run("shl_0",     4'd10, 8'h81, 8'h08, 1'b0, 1'b0, ex(8'h81, 0, 0, 1, 0), 1, 0);
    run("shr_1",     4'd11, 8'h01, 8'h01, 1'b0, 1'b0, ex(8'h00, 1, 1, 0, 0), 2, 1);
    run("shl_7",     4'd10, 8'hC0, 8'h07, 1'b0, 1'b0, ex(8'h00, 0, 1, 0, 0), 8, 7);
    run("rol_4",     4'd12, 8'h96, 8'h04, 1'b0, 1'b0, ex(8'h69, 0, 0, 0, 0), 5, 4);
    run("shr_7",     4'd11, 8'h80, 8'h07, 1'b0, 1'b0, ex(8'h01, 0, 0, 0, 0), 8, 7);

    // Accumulator chain, one op per cycle.
    OP_CODE = 4'd0; left_operand = 8'h01; right_operand = 8'h01; carry_in = 1'b0; acc_sel = 1'b0;
    in_valid = 1'b1;
    chk("b2b_ready0", in_ready, 1'b1);
    sb.push_back(ex(8'h02, 0, 0, 0, 0));
    step();
    chk("b2b_res0", op_out, 8'h02);
    for (int k = 0; k < 3; k++) begin
      acc_sel = 1'b1; left_operand = 8'h00;
      chk("b2b_ready", in_ready, 1'b1);
      sb.push_back(ex(8'h03 + 8'(k), 0, 0, 0, 0));
      step();
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_res", op_out, 8'h03 + 8'(k));
    end
    in_valid = 1'b0; acc_sel = 1'b0;
    step();
    chk("b2b_idle", out_valid, 1'b0);

    // Consumer stall in DONE; offered op must be ignored.
    out_ready = 1'b0;
    issue(4'd4, 8'hAA, 8'hFF, 1'b0, 1'b0, ex(8'h55, 0, 0, 0, 0), 1'b1);
    OP_CODE = 4'd6; left_operand = 8'h11; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_op_out", op_out, 8'h55);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_released", out_valid, 1'b0);

    // CE freeze mid-EXEC: 2 shifts done, 4 frozen cycles, 4 shifts remain.
    issue(4'd10, 8'h01, 8'h06, 1'b0, 1'b0, ex(8'h40, 0, 0, 0, 0), 1'b1);
    step();
    step();
    CE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ce_busy_hold", busy, 1'b1);
      chk("ce_in_ready", in_ready, 1'b0);
      step();
    end
    chk("ce_no_result", out_valid, 1'b0);
    CE = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("ce_resume_cycles", n, 4);
    CE = 1'b0;
    step();
    step();
    chk("ce_done_hold", out_valid, 1'b1);
    chk("ce_done_op_out", op_out, 8'h40);
    CE = 1'b1;
    step();

    // Reset during EXEC discards the operation.
    issue(4'd10, 8'hFF, 8'h07, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("rst_op_out", op_out, 8'h00);
    chk("rst_flags", {carry_out, zero_flag, neg_flag, ovf_flag}, 4'b0000);
    chk("rst_valid_busy", {out_valid, busy}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_no_valid", out_valid, 1'b0);
    run("acc_after_rst", 4'd0, 8'hEE, 8'h05, 1'b0, 1'b1, ex(8'h05, 0, 0, 0, 0), 1, 0);

    step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
